// File: rtl/pc_ctrl.sv
// PC sequencing controller: arbitrates memory stalls, illegal-opcode traps and
// external interrupts. Optional performance counters: PC_CTRL_PERFCNT_EN.
module pc_ctrl #(
  parameter int SYNC_STAGES = 2  // irq synchroniser depth, 2..4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        illop,
  input  logic        mem_busy,
  input  logic [31:0] ia,
  input  logic [31:0] PCp4,
  output logic        Stall,
  output logic [1:0]  PCSel,
  output logic [31:0] XP,
  output logic        irq_ack,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count,
  output logic [31:0] trap_count,
  output logic        fsm_state,
  output logic        irq_pend
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam logic [1:0]  SEL_DEFAULT = 2'b00;
  localparam logic [1:0]  SEL_XADR    = 2'b01;
  localparam logic [1:0]  SEL_ILLOP   = 2'b10;
  localparam logic [31:0] XP_RESET    = 32'h8000_0000;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   pend_q;
  logic [31:0]            xp_q;
  logic                   irq_edge;
  logic                   stall_c;
  logic [1:0]             sel_c;
  logic                   ack_c;
  logic                   capture_c;
  logic                   unused_ia_bits;

  // Only the supervisor bit of the instruction address matters here.
  assign unused_ia_bits = ^ia[30:0];

  assign irq_edge = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // Valid/ready-free sideband: pc consumes Stall/PCSel/irq_ack in the same
  // cycle they are asserted; the trap is committed at the next rising edge.
  always_comb begin
    stall_c    = 1'b0;
    sel_c      = SEL_DEFAULT;
    ack_c      = 1'b0;
    capture_c  = 1'b0;
    state_next = RUN;
    if (!reset) begin
      state_next = RUN;
    end else if (mem_busy) begin
      stall_c    = 1'b1;
      state_next = state;
    end else if (illop) begin
      sel_c      = SEL_ILLOP;
      capture_c  = 1'b1;
      state_next = TRAP;
    end else if (state == RUN && pend_q && !ia[31]) begin
      sel_c      = SEL_XADR;
      ack_c      = 1'b1;
      capture_c  = 1'b1;
      state_next = TRAP;
    end else begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      sync_q    <= {SYNC_STAGES{1'b0}};
      sync_prev <= 1'b0;
      pend_q    <= 1'b0;
      xp_q      <= XP_RESET;
    end else begin
      state     <= state_next;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq};
      sync_prev <= sync_q[SYNC_STAGES-1];
      // A fresh edge in the ack cycle keeps the request pending.
      pend_q    <= irq_edge | (pend_q & ~ack_c);
      if (capture_c) xp_q <= PCp4;
    end
  end

  assign Stall     = stall_c;
  assign PCSel     = sel_c;
  assign irq_ack   = ack_c;
  assign XP        = reset ? xp_q : XP_RESET;
  assign fsm_state = state;
  assign irq_pend  = pend_q;

`ifdef PC_CTRL_PERFCNT_EN
  logic [31:0] instr_q;
  logic [31:0] stall_q;
  logic [31:0] trap_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= 32'd0;
      stall_q <= 32'd0;
      trap_q  <= 32'd0;
    end else begin
      if (!stall_c && sel_c == SEL_DEFAULT) instr_q <= instr_q + 32'd1;
      if (stall_c) stall_q <= stall_q + 32'd1;
      if (sel_c == SEL_XADR || sel_c == SEL_ILLOP) trap_q <= trap_q + 32'd1;
    end
  end

  assign instr_count = reset ? instr_q : 32'd0;
  assign stall_count = reset ? stall_q : 32'd0;
  assign trap_count  = reset ? trap_q  : 32'd0;
`else
  assign instr_count = 32'd0;
  assign stall_count = 32'd0;
  assign trap_count  = 32'd0;
`endif

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter sequencing controller for the single-cycle MIPS core. It sits beside `pc` and drives its `Stall` and `PCSel` inputs. It arbitrates between memory wait-states, illegal-opcode traps and external interrupts, and captures the return address into the exception-PC register `XP`. It also synchronises and latches the external interrupt request and masks it while the core runs in supervisor mode.

## Interface
- `SYNC_STAGES`, 2, number of flip-flops in the `irq` synchroniser (legal 2–4).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `irq`  in  1  external interrupt request; asynchronous, rising-edge significant.
- `illop`  in  1  decoder flag: the current instruction's opcode is illegal.
- `mem_busy`  in  1  instruction/data memory not ready; the PC must hold.
- `ia`  in  32  current instruction address; bit 31 is the supervisor bit (1 = supervisor).
- `PCp4`  in  32  `ia + 4`.
- `Stall`  out  1  hold the PC.
- `PCSel`  out  2  00 = default/jump, 01 = interrupt (`XADR`), 10 = illegal opcode (`ILLOP`); 11 is never driven.
- `XP`  out  32  saved return address (`PCp4` of the trapped instruction).
- `irq_ack`  out  1  one-cycle pulse in the cycle an interrupt is taken.
- `instr_count`, `stall_count`, `trap_count`  out  32 each  performance counters (see Configuration).

## Operation
- **Interrupt front end**
  - `irq` passes through `SYNC_STAGES` flip-flops, then a rising-edge detector.
  - A detected edge sets the sticky `irq_pend`.
  - `irq_pend` clears only on `irq_ack`.
  - If a new edge and `irq_ack` coincide, `irq_pend` stays 1.
- **FSM states:** RUN and TRAP.
- **RUN.** Priority is evaluated combinationally each cycle:
  1. `mem_busy` = 1: `Stall` = 1, `PCSel` = 00, stay in RUN. `illop` and `irq_pend` are deferred and re-evaluated next cycle.
  2. `illop` = 1: `PCSel` = 10, `XP` <= `PCp4`, go to TRAP.
  3. `irq_pend` = 1 and `ia[31]` = 0: `PCSel` = 01, `irq_ack` = 1, `XP` <= `PCp4`, go to TRAP.
  4. Otherwise: `Stall` = 0, `PCSel` = 00.
- **TRAP.** Lasts exactly one cycle (the handler's first fetch), then returns to RUN.
  - `irq_pend` is masked regardless of `ia[31]`.
  - `mem_busy` holds the FSM in TRAP with `Stall` = 1.
  - `illop` in TRAP (fault in the handler) is taken as in RUN: `PCSel` = 10, `XP` overwritten, stay in TRAP.
- **Supervisor mode.** While `ia[31]` = 1, interrupts stay pending and are taken on the first eligible RUN cycle after `ia[31]` returns to 0.
- **Illegal-opcode versus interrupt.** `illop` always beats a pending interrupt in the same cycle; the interrupt stays pending.
- **Reset values** (while `reset` = 0 at a clock edge, and on all outputs the following cycle):
  - FSM = RUN, `irq_pend` = 0, synchroniser = 0.
  - `XP` = 0x80000000, counters = 0.
  - `Stall` = 0, `PCSel` = 00, `irq_ack` = 0.
  - Outputs are forced to these values combinationally while `reset` = 0.

## Timing
- `Stall`, `PCSel` and `irq_ack` are combinational from the FSM, `irq_pend`, `illop`, `mem_busy` and `ia`: zero-cycle latency to `pc`.
- `XP`, the FSM, `irq_pend` and the counters update on the same edge at which `pc` loads the handler address.
- `irq` to `irq_pend` visible: `SYNC_STAGES` + 1 edges.
- Earliest `irq_ack` is the cycle after that.
- Reset has priority over every event. A reset during TRAP or during a stall returns to RUN with the reset values and discards a pending interrupt.

## Configuration
- **Macro:** `PC_CTRL_PERFCNT_EN`.
- **Defined:**
  - `instr_count` increments each cycle with `Stall` = 0 and `PCSel` = 00.
  - `stall_count` increments each cycle with `Stall` = 1.
  - `trap_count` increments each cycle `PCSel` is 01 or 10.
  - All counters wrap modulo 2^32.
- **Undefined:** the counter ports remain but are tied to 0 and no counter flops are built.

## Test plan
- **Reset and idle.** Hold `reset` = 0 for 2 cycles, then 1 with all inputs 0. Required: `Stall` = 0, `PCSel` = 00, `XP` = 0x80000000, `irq_ack` = 0 every cycle.
- **Illegal opcode.** `ia` = 0x00000100, `PCp4` = 0x00000104, `illop` = 1 for 1 cycle. Required: `PCSel` = 10 that cycle, `XP` = 0x00000104 next cycle, FSM in TRAP for 1 cycle then RUN.
- **Interrupt latency and masking.**
  - With `SYNC_STAGES` = 2, `ia[31]` = 0, pulse `irq` high. Required: `irq_ack` and `PCSel` = 01 exactly 4 edges later; `irq_pend` clears.
  - Repeat with `ia[31]` = 1 for 10 cycles, then 0. Required: ack on the first RUN cycle after the drop.
- **Stall priority.** `mem_busy` = 1 for 3 cycles with `illop` = 1 and `irq_pend` = 1. Required: `Stall` = 1, `PCSel` = 00 for 3 cycles; then `PCSel` = 10; the interrupt is taken after TRAP.
- **Reset mid-trap.** Assert `reset` = 0 during TRAP with `irq_pend` = 1. Required: next cycle RUN, `irq_pend` = 0, `XP` = 0x80000000.
- **Counters (macro defined).** Run 5 normal cycles, 2 stall cycles and 1 trap from reset. Required: `instr_count` = 5, `stall_count` = 2, `trap_count` = 1. Preset `instr_count` to 0xFFFFFFFF via force; the next normal cycle must wrap it to 0.
